// File: rtl/full_adder_16bit_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands and carry-in; the slave returns the registered sum and carry-out.
interface full_adder_16bit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (output a, b, cin, input  s, cout);
  modport slave  (input  a, b, cin, output s, cout);
endinterface

// File: rtl/full_adder_16bit.sv
// Registered WIDTH-bit ripple-carry adder built from a chain of single-bit full-adder cells.
// {cout,s} is A + B + CIN, registered with one cycle of latency and a synchronous active-low clear.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module full_adder_16bit #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  full_adder_16bit_if.slave  bus
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;

  assign op_a = bus.a;
  assign op_b = bus.b;
  assign c[0] = bus.cin;

  // Bit i's carry-out feeds bit i+1's carry-in, forming a pure ripple chain.
  fa_cell u_cell [WIDTH-1:0] (
    .a  (op_a),
    .b  (op_b),
    .ci (c[WIDTH-1:0]),
    .s  (sum),
    .co (c[WIDTH:1])
  );

  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= sum;
      cout_q <= c[WIDTH];
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_full_adder_16bit.sv
// Directed and random checks of the registered 16-bit adder.
// A scoreboard queue holds each vector's expected result until the edge that registers it.
module tb_full_adder_16bit;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    string       tag;
  } exp_t;

  exp_t sb[$];

  full_adder_16bit_if #(.WIDTH(16)) bus ();

  full_adder_16bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic push(input logic r, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input string tag);
    exp_t e;
    logic [16:0] full;
    full   = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    e.s    = r ? full[15:0] : 16'h0000;
    e.cout = r ? full[16]   : 1'b0;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: observed no pending entry, required one");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (bus.s === e.s) else begin
      failures++;
      $error("FAIL %s.s observed=%h expected=%h", e.tag, bus.s, e.s);
    end
    checks++;
    assert (bus.cout === e.cout) else begin
      failures++;
      $error("FAIL %s.cout observed=%b expected=%b", e.tag, bus.cout, e.cout);
    end
  endtask

  // One operation per cycle: drive at negedge, check #1 after the next posedge.
  task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input string tag);
    @(negedge clk);
    rst_n   = r;
    bus.a   = a;
    bus.b   = b;
    bus.cin = ci;
    push(r, a, b, ci, tag);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    bus.cin  = 1'b0;

    step(1'b0, 16'h1234, 16'h1111, 1'b1, "reset");
    step(1'b1, 16'h0003, 16'h0005, 1'b0, "add_3_5");
    step(1'b1, 16'h000F, 16'h0001, 1'b1, "nibble_cin");
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, "wrap_ffff_1");
    step(1'b1, 16'h8000, 16'h8000, 1'b0, "msb_carry");
    step(1'b1, 16'h1234, 16'h0000, 1'b0, "pass_1234");
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "all_ones_cin");
    step(1'b1, 16'h5555, 16'hAAAA, 1'b1, "alt_ripple");
    step(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, "mid_reset");
    step(1'b1, 16'h00FF, 16'h0F01, 1'b0, "post_release");

    // Hold check: outputs must not move between edges.
    @(negedge clk);
    checks++;
    assert (bus.s === 16'h1000) else begin
      failures++;
      $error("FAIL hold.s observed=%h expected=%h", bus.s, 16'h1000);
    end

    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), "random");
    end

    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "final_ffff");

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
